mem_1: RTL
==========

MEM_1 -- requirements
Module: mem_1

Interface
REQ-001 The block SHALL have this parameter: TIMEOUT_CYCLES, default 16, maximum ACCESS-state cycles to wait for dmem_ack (legal range 2..255).
REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- m0_m1_oper  in  1  upstream slot valid.
- m0_m1_readmem  in  1  load.
- m0_m1_writemem  in  1  store.
- m0_m1_data_addr  in  32  effective address or ALU result.
- m0_m1_regb  in  32  store data.
- m0_m1_regdest  in  5  destination register.
- m0_m1_writereg  in  1  register write enable.
- m1_stall  out  1  upstream hold request.
- dmem_req  out  1  data-memory request.
- dmem_we  out  1  1 = write.
- dmem_addr  out  32  access address.
- dmem_wdata  out  32  store data.
- dmem_ack  in  1  one-cycle completion strobe.
- dmem_rdata  in  32  load data, valid with dmem_ack.
- m1_wb_oper  out  1  writeback slot valid.
- m1_wb_memtoreg  out  1  select memdata for writeback.
- m1_wb_memdata  out  32  load result.
- m1_wb_aluout  out  32  passed-through m0_m1_data_addr.
- m1_wb_regdest  out  5  destination register.
- m1_wb_writereg  out  1  register write enable.
- m1_err  out  1  one-cycle fault pulse.

Function
REQ-003 The block SHALL implement a two-state FSM: IDLE and ACCESS.
REQ-004 m1_stall SHALL be combinational, equal to (state == ACCESS); inputs SHALL be sampled only in IDLE.
REQ-005 In IDLE with m0_m1_oper=0, the block SHALL zero all m1_wb_* outputs and m1_err at the next edge (bubble).
REQ-006 In IDLE with oper=1 and readmem=writemem=0, the block SHALL, at the next edge (1-cycle latency), drive wb_oper=1, wb_memtoreg=0, wb_aluout=data_addr, wb_memdata=0, and pass regdest/writereg through.
REQ-007 In IDLE with oper=1 and readmem or writemem set, the block SHALL latch all inputs, enter ACCESS, and drive wb_oper=0 at the next edge.
REQ-008 When readmem and writemem are both set, the block SHALL treat the operation as a store.
REQ-009 In ACCESS, dmem_req SHALL be 1, and dmem_we, dmem_addr and dmem_wdata SHALL hold the latched values, stable until completion.
REQ-010 A dmem_ack in ACCESS SHALL cause the following at that edge: return to IDLE; wb_oper=1; wb_memtoreg=readmem; wb_memdata=dmem_rdata on loads, else 0; wb_aluout=latched address; latched regdest; wb_writereg=latched writereg on loads, else 0.
REQ-011 The block SHALL ignore dmem_ack while in IDLE.
REQ-012 The block SHALL count ACCESS cycles with an 8-bit counter cleared on entry.
REQ-013 If no ack arrives by the TIMEOUT_CYCLES-th ACCESS cycle, the block SHALL return to IDLE at that edge and drive wb_oper=1, wb_writereg=0, wb_memtoreg=0 and m1_err=1 for one cycle.
REQ-014 A dmem_ack arriving on the timeout cycle SHALL take precedence as a normal completion.
REQ-015 On leaving ACCESS, the instruction held upstream SHALL be sampled at the following edge, giving exactly one bubble per memory access.
REQ-016 dmem_req SHALL never be asserted in IDLE.

Reset
REQ-017 When reset=1 at a rising edge, the block SHALL enter IDLE, clear the counter, and zero all registered outputs, so dmem_req=0 and m1_stall=0 in the next cycle.
REQ-018 Reset SHALL take precedence over all other inputs.
REQ-019 Reset during ACCESS SHALL abandon the access; an ack arriving afterwards SHALL be ignored.

Configuration
REQ-020 With MEM1_ALIGN_CHECK_EN defined, a memory operation accepted in IDLE with data_addr[1:0]!=0 SHALL issue no request, stay in IDLE, and at the next edge drive wb_oper=1, wb_writereg=0 and m1_err=1.
REQ-021 Without MEM1_ALIGN_CHECK_EN, the access SHALL proceed with dmem_addr={data_addr[31:2],2'b00}, and m1_err SHALL pulse only on timeout.

Verification
REQ-022 The bench SHALL cover: ALU pass-through with oper=1, addr=0x0000_1234, regdest=5, writereg=1 -> next cycle wb_oper=1, aluout=0x1234, memtoreg=0, stall never asserted.
REQ-023 The bench SHALL cover: load from addr=0x100 with ack on the 3rd ACCESS cycle, rdata=0xDEADBEEF -> stall high for 3 cycles; wb_memdata=0xDEADBEEF, memtoreg=1, writereg=1.
REQ-024 The bench SHALL cover: store of addr=0x200, regb=0xCAFEF00D -> dmem_we=1, wdata=0xCAFEF00D held until ack; wb_writereg=0.
REQ-025 The bench SHALL cover: load with no ack and TIMEOUT_CYCLES=4 -> req deasserted after 4 ACCESS cycles; m1_err pulse; wb_writereg=0.
REQ-026 The bench SHALL cover: reset asserted on the 2nd ACCESS cycle, then ack one cycle later -> req=0 and all outputs zero after the reset edge; the late ack produces no wb_oper.
REQ-027 The bench SHALL cover: with MEM1_ALIGN_CHECK_EN defined, a load at addr=0x102 -> no dmem_req; next cycle m1_err=1 and wb_writereg=0.

Source files
------------

// File: rtl/mem_1.sv
// MEM1 pipeline stage: passes ALU results through in one cycle and runs loads/stores
// against a handshaked data memory with a bounded wait. Optional: MEM1_ALIGN_CHECK_EN.
module mem_1 #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        m0_m1_oper,
  input  logic        m0_m1_readmem,
  input  logic        m0_m1_writemem,
  input  logic [31:0] m0_m1_data_addr,
  input  logic [31:0] m0_m1_regb,
  input  logic [4:0]  m0_m1_regdest,
  input  logic        m0_m1_writereg,
  output logic        m1_stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        m1_wb_oper,
  output logic        m1_wb_memtoreg,
  output logic [31:0] m1_wb_memdata,
  output logic [31:0] m1_wb_aluout,
  output logic [4:0]  m1_wb_regdest,
  output logic        m1_wb_writereg,
  output logic        m1_err
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam logic [7:0] LAST_CYCLE = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_reg, state_next;
  logic [7:0]  cnt_reg, cnt_next;

  logic        acc_we_reg, acc_we_next;
  logic        acc_rd_reg, acc_rd_next;
  logic [31:0] acc_addr_reg, acc_addr_next;
  logic [31:0] acc_wdata_reg, acc_wdata_next;
  logic [4:0]  acc_regdest_reg, acc_regdest_next;
  logic        acc_writereg_reg, acc_writereg_next;

  logic        wb_oper_reg, wb_oper_next;
  logic        wb_memtoreg_reg, wb_memtoreg_next;
  logic [31:0] wb_memdata_reg, wb_memdata_next;
  logic [31:0] wb_aluout_reg, wb_aluout_next;
  logic [4:0]  wb_regdest_reg, wb_regdest_next;
  logic        wb_writereg_reg, wb_writereg_next;
  logic        err_reg, err_next;

  logic        mem_op;
  logic        align_fault;
  logic        timeout_hit;

  assign mem_op      = m0_m1_oper & (m0_m1_readmem | m0_m1_writemem);
  assign timeout_hit = (cnt_reg == LAST_CYCLE);

`ifdef MEM1_ALIGN_CHECK_EN
  assign align_fault = (m0_m1_data_addr[1:0] != 2'b00);
`else
  assign align_fault = 1'b0;
`endif

  // State and datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg        <= IDLE;
      cnt_reg          <= 8'd0;
      acc_we_reg       <= 1'b0;
      acc_rd_reg       <= 1'b0;
      acc_addr_reg     <= 32'd0;
      acc_wdata_reg    <= 32'd0;
      acc_regdest_reg  <= 5'd0;
      acc_writereg_reg <= 1'b0;
      wb_oper_reg      <= 1'b0;
      wb_memtoreg_reg  <= 1'b0;
      wb_memdata_reg   <= 32'd0;
      wb_aluout_reg    <= 32'd0;
      wb_regdest_reg   <= 5'd0;
      wb_writereg_reg  <= 1'b0;
      err_reg          <= 1'b0;
    end else begin
      state_reg        <= state_next;
      cnt_reg          <= cnt_next;
      acc_we_reg       <= acc_we_next;
      acc_rd_reg       <= acc_rd_next;
      acc_addr_reg     <= acc_addr_next;
      acc_wdata_reg    <= acc_wdata_next;
      acc_regdest_reg  <= acc_regdest_next;
      acc_writereg_reg <= acc_writereg_next;
      wb_oper_reg      <= wb_oper_next;
      wb_memtoreg_reg  <= wb_memtoreg_next;
      wb_memdata_reg   <= wb_memdata_next;
      wb_aluout_reg    <= wb_aluout_next;
      wb_regdest_reg   <= wb_regdest_next;
      wb_writereg_reg  <= wb_writereg_next;
      err_reg          <= err_next;
    end
  end

  // Next-state logic; the cycle counter restarts on every ACCESS entry
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        cnt_next = 8'd0;
        if (mem_op && !align_fault) begin
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        if (dmem_ack || timeout_hit) begin
          state_next = IDLE;
          cnt_next   = 8'd0;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 8'd0;
      end
    endcase
  end

  // Output logic: writeback slot defaults to a bubble
  always_comb begin
    acc_we_next       = acc_we_reg;
    acc_rd_next       = acc_rd_reg;
    acc_addr_next     = acc_addr_reg;
    acc_wdata_next    = acc_wdata_reg;
    acc_regdest_next  = acc_regdest_reg;
    acc_writereg_next = acc_writereg_reg;
    wb_oper_next      = 1'b0;
    wb_memtoreg_next  = 1'b0;
    wb_memdata_next   = 32'd0;
    wb_aluout_next    = 32'd0;
    wb_regdest_next   = 5'd0;
    wb_writereg_next  = 1'b0;
    err_next          = 1'b0;
    case (state_reg)
      IDLE: begin
        if (m0_m1_oper) begin
          if (!mem_op) begin
            wb_oper_next     = 1'b1;
            wb_aluout_next   = m0_m1_data_addr;
            wb_regdest_next  = m0_m1_regdest;
            wb_writereg_next = m0_m1_writereg;
          end else if (align_fault) begin
            wb_oper_next    = 1'b1;
            wb_aluout_next  = m0_m1_data_addr;
            wb_regdest_next = m0_m1_regdest;
            err_next        = 1'b1;
          end else begin
            // A slot flagged as both load and store is executed as a store
            acc_we_next       = m0_m1_writemem;
            acc_rd_next       = m0_m1_readmem & ~m0_m1_writemem;
            acc_addr_next     = m0_m1_data_addr;
            acc_wdata_next    = m0_m1_regb;
            acc_regdest_next  = m0_m1_regdest;
            acc_writereg_next = m0_m1_writereg;
          end
        end
      end
      ACCESS: begin
        if (dmem_ack) begin
          wb_oper_next     = 1'b1;
          wb_memtoreg_next = acc_rd_reg;
          wb_memdata_next  = acc_rd_reg ? dmem_rdata : 32'd0;
          wb_aluout_next   = acc_addr_reg;
          wb_regdest_next  = acc_regdest_reg;
          wb_writereg_next = acc_rd_reg & acc_writereg_reg;
        end else if (timeout_hit) begin
          wb_oper_next    = 1'b1;
          wb_aluout_next  = acc_addr_reg;
          wb_regdest_next = acc_regdest_reg;
          err_next        = 1'b1;
        end
      end
      default: begin
        wb_oper_next = 1'b0;
      end
    endcase
  end

  assign m1_stall   = (state_reg == ACCESS);
  assign dmem_req   = (state_reg == ACCESS);
  assign dmem_we    = (state_reg == ACCESS) & acc_we_reg;
  assign dmem_addr  = {acc_addr_reg[31:2], 2'b00};
  assign dmem_wdata = acc_wdata_reg;

  assign m1_wb_oper     = wb_oper_reg;
  assign m1_wb_memtoreg = wb_memtoreg_reg;
  assign m1_wb_memdata  = wb_memdata_reg;
  assign m1_wb_aluout   = wb_aluout_reg;
  assign m1_wb_regdest  = wb_regdest_reg;
  assign m1_wb_writereg = wb_writereg_reg;
  assign m1_err         = err_reg;

endmodule
